// File: rtl/ice40_ml_frame_pingpong.sv
// ice40_ml_frame_pingpong
// Ping-pong frame buffer between the gray-video downscaler and the ML engine.
// Two 1024x16 banks: one is filled from the downscaler's write burst while the
// other is published to the ML engine. A filled frame is published on the
// downscaler's done flag, together with its signed sample sum and a frame
// count. Read-ready is withheld while both banks are occupied, so a published
// frame is never overwritten.
//
// Ports:
//   clk, resetn            system clock, asynchronous active-low reset
//   o_rd_rdy               a free bank is armed for filling
//   i_rd_req, o_busy       downscaler activity status
//   i_rd_done              downscaler frame-done level
//   i_we/i_waddr/i_din     sample write port
//   i_ml_raddr/o_ml_rdata  ML read port, 1-cycle registered latency
//   o_ml_frame_vld         read bank holds a published frame
//   i_ml_frame_ack         ML releases the read bank
//   o_ml_bank              current read bank index
//   o_frame_sum/o_frame_cnt  sum and count of published frames
//   o_err_short/o_err_oob  sticky error flags
module ice40_ml_frame_pingpong #(
  parameter int FRAME_WORDS = 1024,
  parameter int ADDR_W      = 10,
  parameter int SUM_W       = 26
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    o_rd_rdy,
  input  logic                    i_rd_req,
  input  logic                    i_rd_done,
  input  logic                    i_we,
  input  logic [15:0]             i_waddr,
  input  logic [15:0]             i_din,
  input  logic [ADDR_W-1:0]       i_ml_raddr,
  output logic [15:0]             o_ml_rdata,
  output logic                    o_ml_frame_vld,
  input  logic                    i_ml_frame_ack,
  output logic                    o_ml_bank,
  output logic signed [SUM_W-1:0] o_frame_sum,
  output logic [7:0]              o_frame_cnt,
  output logic                    o_busy,
  output logic                    o_err_short,
  output logic                    o_err_oob
);

  typedef enum logic [1:0] {IDLE, FILL, DONE_WAIT, STALL} state_t;

  state_t state, state_nxt;

  logic [1:0]              full;
  logic                    wbank;
  logic                    rbank;
  logic [ADDR_W:0]         wcnt;
  logic [ADDR_W:0]         wcnt_nxt;
  logic signed [SUM_W-1:0] acc;
  logic signed [SUM_W-1:0] acc_nxt;
  logic [15:0]             mem [0:2*FRAME_WORDS-1];

  logic in_range;
  logic wr_ok;
  logic wr_oob;
  logic done_seen;
  logic publish;
  logic ack_ok;
  logic fill_entry;

  assign in_range   = (i_waddr < 16'(FRAME_WORDS));
  assign wr_ok      = (state == FILL) && i_we && in_range;
  assign wr_oob     = (state == FILL) && i_we && !in_range;
  assign done_seen  = (state == FILL) && i_rd_done;
  assign ack_ok     = i_ml_frame_ack && o_ml_frame_vld;
  assign fill_entry = (state_nxt == FILL) && (state != FILL);

  // The same-cycle write is folded in before the done decision. The counter
  // stops one past a full frame so an overlong burst can never wrap back to
  // an exact match.
  always_comb begin
    wcnt_nxt = wcnt;
    acc_nxt  = acc;
    if (wr_ok) begin
      acc_nxt = acc + {{(SUM_W-16){i_din[15]}}, i_din};
      if (wcnt <= (ADDR_W+1)'(FRAME_WORDS)) begin
        wcnt_nxt = wcnt + 1'b1;
      end
    end
  end

  assign publish = done_seen && (wcnt_nxt == (ADDR_W+1)'(FRAME_WORDS));

  // Fill FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fill FSM next state: after a done, wait for the level to drop, then
  // resume filling only if the next write bank has been released.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = FILL;
      FILL:      if (i_rd_done) state_nxt = DONE_WAIT;
      DONE_WAIT: if (!i_rd_done) state_nxt = full[wbank] ? STALL : FILL;
      STALL:     if (!full[wbank]) state_nxt = FILL;
      default:   state_nxt = IDLE;
    endcase
  end

  // Fill FSM outputs.
  always_comb begin
    o_rd_rdy = (state == FILL);
    o_busy   = i_rd_req || (state == FILL);
  end

  // Bank bookkeeping, frame statistics and sticky errors. Publish always
  // targets wbank and ack always targets rbank, which differ whenever both
  // fire, so both updates can be applied in the same cycle. The valid flag
  // is forced low on an ack so a stale 1 never lingers for the old bank.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full           <= '0;
      wbank          <= 1'b0;
      rbank          <= 1'b0;
      wcnt           <= '0;
      acc            <= '0;
      o_ml_frame_vld <= 1'b0;
      o_frame_sum    <= '0;
      o_frame_cnt    <= '0;
      o_err_short    <= 1'b0;
      o_err_oob      <= 1'b0;
    end else begin
      if (fill_entry) begin
        wcnt <= '0;
        acc  <= '0;
      end else begin
        wcnt <= wcnt_nxt;
        acc  <= acc_nxt;
      end

      if (wr_oob) begin
        o_err_oob <= 1'b1;
      end

      if (done_seen && !publish) begin
        o_err_short <= 1'b1;
      end

      if (publish) begin
        full[wbank] <= 1'b1;
        wbank       <= ~wbank;
        o_frame_sum <= acc_nxt;
        o_frame_cnt <= o_frame_cnt + 8'd1;
      end

      if (ack_ok) begin
        full[rbank]    <= 1'b0;
        rbank          <= ~rbank;
        o_ml_frame_vld <= 1'b0;
      end else begin
        o_ml_frame_vld <= full[rbank];
      end
    end
  end

  // Bank RAM write port; the bank select is the top address bit.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[{wbank, i_waddr[ADDR_W-1:0]}] <= i_din;
    end
  end

  // Registered ML read port, independent of the valid flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_ml_rdata <= '0;
    end else begin
      o_ml_rdata <= mem[{rbank, i_ml_raddr}];
    end
  end

  assign o_ml_bank = rbank;

endmodule

// File: tb/tb_ice40_ml_frame_pingpong.sv
// Testbench for ice40_ml_frame_pingpong: directed frames through both banks,
// a table of ML read vectors, and hand-written multi-cycle corner cases.
module tb_ice40_ml_frame_pingpong;

  logic        clk = 1'b0;
  logic        resetn;
  logic        o_rd_rdy;
  logic        i_rd_req;
  logic        i_rd_done;
  logic        i_we;
  logic [15:0] i_waddr;
  logic [15:0] i_din;
  logic [9:0]  i_ml_raddr;
  logic [15:0] o_ml_rdata;
  logic        o_ml_frame_vld;
  logic        i_ml_frame_ack;
  logic        o_ml_bank;
  logic [25:0] o_frame_sum;
  logic [7:0]  o_frame_cnt;
  logic        o_busy;
  logic        o_err_short;
  logic        o_err_oob;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [9:0]  raddr;
    logic [15:0] exp_data;
  } read_vec_t;

  read_vec_t rd_table [6];

  ice40_ml_frame_pingpong dut (
    .clk            (clk),
    .resetn         (resetn),
    .o_rd_rdy       (o_rd_rdy),
    .i_rd_req       (i_rd_req),
    .i_rd_done      (i_rd_done),
    .i_we           (i_we),
    .i_waddr        (i_waddr),
    .i_din          (i_din),
    .i_ml_raddr     (i_ml_raddr),
    .o_ml_rdata     (o_ml_rdata),
    .o_ml_frame_vld (o_ml_frame_vld),
    .i_ml_frame_ack (i_ml_frame_ack),
    .o_ml_bank      (o_ml_bank),
    .o_frame_sum    (o_frame_sum),
    .o_frame_cnt    (o_frame_cnt),
    .o_busy         (o_busy),
    .o_err_short    (o_err_short),
    .o_err_oob      (o_err_oob)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] raddr);
    i_ml_raddr = raddr;
    tick();
  endtask

  // mode 0: constant value; mode 1: ramp k-512.
  task automatic write_frame(input int n, input int mode, input logic [15:0] value);
    for (int k = 0; k < n; k++) begin
      i_we    = 1'b1;
      i_waddr = 16'(k);
      i_din   = (mode == 1) ? 16'(k - 512) : value;
      tick();
    end
    i_we = 1'b0;
  endtask

  // Raise done, wait (bounded) for read-ready to drop, then release done.
  task automatic finish_frame();
    int wait_cnt;
    i_rd_done = 1'b1;
    tick();
    wait_cnt = 0;
    while (o_rd_rdy !== 1'b0 && wait_cnt < 8) begin
      tick();
      wait_cnt++;
    end
    checkOutput("rd_rdy_drop", 32'(o_rd_rdy), 32'd0);
    i_rd_done = 1'b0;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_rd_rdy"},    32'(o_rd_rdy), 32'd0);
    checkOutput({tag, "_vld"},       32'(o_ml_frame_vld), 32'd0);
    checkOutput({tag, "_bank"},      32'(o_ml_bank), 32'd0);
    checkOutput({tag, "_rdata"},     32'(o_ml_rdata), 32'd0);
    checkOutput({tag, "_sum"},       32'(o_frame_sum), 32'd0);
    checkOutput({tag, "_cnt"},       32'(o_frame_cnt), 32'd0);
    checkOutput({tag, "_err_short"}, 32'(o_err_short), 32'd0);
    checkOutput({tag, "_err_oob"},   32'(o_err_oob), 32'd0);
  endtask

  initial begin
    // Bank-1 frame is a ramp: sample k holds k-512.
    rd_table[0] = '{raddr: 10'd0,    exp_data: 16'hFE00};
    rd_table[1] = '{raddr: 10'd1,    exp_data: 16'hFE01};
    rd_table[2] = '{raddr: 10'd511,  exp_data: 16'hFFFF};
    rd_table[3] = '{raddr: 10'd512,  exp_data: 16'h0000};
    rd_table[4] = '{raddr: 10'd700,  exp_data: 16'h00BC};
    rd_table[5] = '{raddr: 10'd1023, exp_data: 16'h01FF};

    resetn         = 1'b0;
    i_rd_req       = 1'b0;
    i_rd_done      = 1'b0;
    i_we           = 1'b0;
    i_waddr        = '0;
    i_din          = '0;
    i_ml_raddr     = '0;
    i_ml_frame_ack = 1'b0;

    tick();
    tick();
    check_reset_values("rst");
    resetn = 1'b1;
    tick();
    checkOutput("rdy_after_reset", 32'(o_rd_rdy), 32'd1);
    checkOutput("busy_fill", 32'(o_busy), 32'd1);

    // Frame A: +1 into bank 0.
    write_frame(1024, 0, 16'h0001);
    finish_frame();
    checkOutput("a_vld", 32'(o_ml_frame_vld), 32'd1);
    checkOutput("a_sum", 32'($signed(o_frame_sum)), 32'd1024);
    checkOutput("a_cnt", 32'(o_frame_cnt), 32'd1);
    checkOutput("a_bank", 32'(o_ml_bank), 32'd0);
    checkOutput("a_rdy", 32'(o_rd_rdy), 32'd1);
    applyStimulus(10'd5);
    checkOutput("a_rdata5", 32'(o_ml_rdata), 32'h0001);

    // Frame B: ramp into bank 1, no ack -> stall.
    write_frame(1024, 1, 16'h0000);
    finish_frame();
    checkOutput("b_sum", 32'($signed(o_frame_sum)), 32'(-512));
    checkOutput("b_cnt", 32'(o_frame_cnt), 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_rdy", 32'(o_rd_rdy), 32'd0);
    end
    checkOutput("stall_busy_idle", 32'(o_busy), 32'd0);
    i_rd_req = 1'b1;
    #1;
    checkOutput("stall_busy_req", 32'(o_busy), 32'd1);
    i_rd_req = 1'b0;

    // Writes outside FILL are ignored, out-of-range or not.
    i_we    = 1'b1;
    i_waddr = 16'h0400;
    i_din   = 16'h7FFF;
    tick();
    i_we = 1'b0;
    checkOutput("stall_write_no_oob", 32'(o_err_oob), 32'd0);
    checkOutput("stall_write_cnt", 32'(o_frame_cnt), 32'd2);

    // One ack releases bank 0; bank 1 becomes the read bank.
    i_ml_frame_ack = 1'b1;
    tick();
    i_ml_frame_ack = 1'b0;
    tick();
    checkOutput("ack_bank", 32'(o_ml_bank), 32'd1);
    checkOutput("ack_vld", 32'(o_ml_frame_vld), 32'd1);
    checkOutput("ack_rdy", 32'(o_rd_rdy), 32'd1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(rd_table[i].raddr);
      checkOutput($sformatf("ramp_rdata_%0d", rd_table[i].raddr),
                  32'(o_ml_rdata), 32'(rd_table[i].exp_data));
    end

    // Release bank 1 so nothing is published.
    i_ml_frame_ack = 1'b1;
    tick();
    i_ml_frame_ack = 1'b0;
    tick();
    checkOutput("ack2_vld", 32'(o_ml_frame_vld), 32'd0);
    checkOutput("ack2_bank", 32'(o_ml_bank), 32'd0);

    // Short frame: 1000 writes.
    write_frame(1000, 0, 16'h0001);
    finish_frame();
    checkOutput("short_err", 32'(o_err_short), 32'd1);
    checkOutput("short_cnt", 32'(o_frame_cnt), 32'd2);
    checkOutput("short_vld", 32'(o_ml_frame_vld), 32'd0);
    checkOutput("short_rdy", 32'(o_rd_rdy), 32'd1);
    checkOutput("short_sum", 32'($signed(o_frame_sum)), 32'(-512));

    // Out-of-range write, then -512 x1024.
    i_we    = 1'b1;
    i_waddr = 16'h0400;
    i_din   = 16'h7FFF;
    tick();
    i_we = 1'b0;
    checkOutput("oob_err", 32'(o_err_oob), 32'd1);
    write_frame(1024, 0, 16'hFE00);
    finish_frame();
    checkOutput("neg_sum", 32'($signed(o_frame_sum)), 32'(-524288));
    checkOutput("neg_cnt", 32'(o_frame_cnt), 32'd3);
    checkOutput("neg_vld", 32'(o_ml_frame_vld), 32'd1);
    checkOutput("neg_bank", 32'(o_ml_bank), 32'd0);
    checkOutput("neg_err_short_sticky", 32'(o_err_short), 32'd1);

    // Last write, done and ack all in one cycle.
    write_frame(1023, 0, 16'h0001);
    i_we           = 1'b1;
    i_waddr        = 16'd1023;
    i_din          = 16'h0001;
    i_rd_done      = 1'b1;
    i_ml_frame_ack = 1'b1;
    tick();
    i_we           = 1'b0;
    i_ml_frame_ack = 1'b0;
    checkOutput("sim_rdy_drop", 32'(o_rd_rdy), 32'd0);
    i_rd_done = 1'b0;
    tick();
    checkOutput("sim_bank", 32'(o_ml_bank), 32'd1);
    checkOutput("sim_vld", 32'(o_ml_frame_vld), 32'd1);
    checkOutput("sim_rdy_fill", 32'(o_rd_rdy), 32'd1);
    checkOutput("sim_sum", 32'($signed(o_frame_sum)), 32'd1024);
    checkOutput("sim_cnt", 32'(o_frame_cnt), 32'd4);
    applyStimulus(10'd1023);
    checkOutput("sim_rdata_last", 32'(o_ml_rdata), 32'h0001);

    // Asynchronous reset mid-fill.
    write_frame(300, 0, 16'h0001);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_values("async");
    tick();
    resetn = 1'b1;
    tick();
    checkOutput("post_rst_rdy", 32'(o_rd_rdy), 32'd1);
    write_frame(1024, 0, 16'h0001);
    finish_frame();
    checkOutput("post_rst_sum", 32'($signed(o_frame_sum)), 32'd1024);
    checkOutput("post_rst_cnt", 32'(o_frame_cnt), 32'd1);
    checkOutput("post_rst_vld", 32'(o_ml_frame_vld), 32'd1);
    checkOutput("post_rst_bank", 32'(o_ml_bank), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
